// File: rtl/vec_result_queue.sv
// Purpose : DEPTH-entry FWFT queue that buffers ALU result vectors (+ tag and lane zero mask) for the register file.
// Latency : enqueue to out_valid is 1 cycle; the head is presented combinationally from storage, with no empty bypass.
// Backpr. : in_ready = (count < DEPTH) comes from registered state only; out_ready never reaches in_ready combinationally.
//
// Ports:
//   clk, reset (async, active-low)
//   in_valid/in_ready/in_result/in_tag/in_op : ALU result producer side
//   flush                                    : synchronous clear; wins over same-cycle push/pop
//   out_valid/out_ready/out_result/out_tag/out_zero_mask : register file consumer side
//   count                                    : occupancy (0..DEPTH)
//   drop_err                                 : sticky; an entry with an undefined op was discarded

module vec_result_queue #(
  parameter int WIDTH = 20,
  parameter int LANES = 8,
  parameter int DEPTH = 4,
  parameter int TAGW  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES-1:0][WIDTH-1:0]   in_result,
  input  logic [TAGW-1:0]               in_tag,
  input  logic [2:0]                    in_op,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES-1:0][WIDTH-1:0]   out_result,
  output logic [TAGW-1:0]               out_tag,
  output logic [LANES-1:0]              out_zero_mask,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          drop_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // ALU op encodings; anything above DIV is undefined and gets dropped.
  localparam logic [2:0] OP_DIV = 3'b100;

  // Entry storage
  logic [LANES-1:0][WIDTH-1:0] r_mem_result [DEPTH];
  logic [TAGW-1:0]             r_mem_tag    [DEPTH];
  logic [LANES-1:0]            r_mem_zmask  [DEPTH];

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_drop_err;

  logic          w_in_hs;
  logic          w_op_bad;
  logic          w_push;
  logic          w_pop;
  logic [PW-1:0] w_wr_ptr_nxt;
  logic [PW-1:0] w_rd_ptr_nxt;
  logic [LANES-1:0] w_zero_mask;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  assign in_ready  = (r_count < CW'(DEPTH));
  assign out_valid = (r_count != '0);

  assign w_in_hs  = in_valid && in_ready;
  assign w_op_bad = (in_op > OP_DIV);

  // An accepted entry with an undefined op is consumed but never stored.
  // Flush cancels both sides for this cycle.
  assign w_push = w_in_hs && !w_op_bad && !flush;
  assign w_pop  = out_valid && out_ready && !flush;

  // Explicit wrap keeps the pointers correct even if the width/depth relation changes.
  assign w_wr_ptr_nxt = (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
  assign w_rd_ptr_nxt = (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);

  // Zero mask is computed once on the way in so the read side is a plain mux.
  always_comb begin
    w_zero_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      w_zero_mask[i] = (in_result[i] == '0);
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers and occupancy
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= w_wr_ptr_nxt;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_nxt;
      end
      // Simultaneous push and pop leaves occupancy unchanged.
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Sticky drop flag: only reset clears it, flush deliberately does not.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_drop_err <= 1'b0;
    end else if (w_in_hs && w_op_bad) begin
      r_drop_err <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Entry storage (data path, no reset needed: validity lives in r_count)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_result[r_wr_ptr] <= in_result;
      r_mem_tag[r_wr_ptr]    <= in_tag;
      r_mem_zmask[r_wr_ptr]  <= w_zero_mask;
    end
  end

  // ---------------------------------------------------------------------------
  // Head presentation: FWFT from storage, forced to zero while empty so stale
  // entries never leak onto the register-file bus.
  // ---------------------------------------------------------------------------
  always_comb begin
    out_result    = '0;
    out_tag       = '0;
    out_zero_mask = '0;
    if (out_valid) begin
      out_result    = r_mem_result[r_rd_ptr];
      out_tag       = r_mem_tag[r_rd_ptr];
      out_zero_mask = r_mem_zmask[r_rd_ptr];
    end
  end

  assign count    = r_count;
  assign drop_err = r_drop_err;

endmodule
